// File: rtl/keymgr_pkg.sv
// Shared types for the key manager sideload path: the key request bundle
// handed to crypto consumers and the producer-side FSM states.
package keymgr_pkg;

  localparam int unsigned KeyWidth  = 256;
  localparam int unsigned NumShares = 2;

  // Share 1 occupies the upper half of key, so the bundle reads {valid, share1, share0}.
  typedef struct packed {
    logic                               valid;
    logic [NumShares-1:0][KeyWidth-1:0] key;
  } hw_key_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StValid,
    StWipe
  } sideload_st_e;

endpackage

// File: rtl/keymgr_sideload_tx.sv
// Assembles a two-share sideload key from a word stream; valid rises 17+ cycles after load_start_i.
// wr_ready_o is high only in LOAD and drops combinationally with clear_i; WIPE takes 16 cycles.
module keymgr_sideload_tx #(
  parameter int unsigned KeyWidth  = keymgr_pkg::KeyWidth,
  parameter int unsigned NumShares = keymgr_pkg::NumShares,
  parameter int unsigned WordWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_start_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [WordWidth-1:0]   wr_data_i,
  input  logic                   clear_i,
  input  logic [WordWidth-1:0]   entropy_i,
  output logic                   busy_o,
  output logic                   done_o,
  output keymgr_pkg::hw_key_req_t keymgr_key_o
);
  import keymgr_pkg::*;

  localparam int unsigned NumWords = NumShares * KeyWidth / WordWidth;
  localparam int unsigned CntW     = $clog2(NumWords);
  localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);

  sideload_st_e                  state;
  logic [CntW-1:0]               cnt;
  logic                          done_q;
  logic [WordWidth-1:0]          mem [NumWords];
  logic [NumShares*KeyWidth-1:0] key_flat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= StIdle;
      cnt    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < int'(NumWords); i++) begin
        mem[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (load_start_i && !clear_i) begin
            state <= StLoad;
            cnt   <= '0;
          end
        end
        StLoad: begin
          // clear_i also masks wr_ready_o, so a coincident word is never a handshake.
          if (clear_i) begin
            state <= StWipe;
            cnt   <= '0;
          end else if (wr_valid_i) begin
            mem[cnt] <= wr_data_i;
            if (cnt == LastWord) begin
              state  <= StValid;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        StValid: begin
          // A reload request must scrub the old key first; the requester restarts afterwards.
          if (clear_i || load_start_i) begin
            state <= StWipe;
            cnt   <= '0;
          end
        end
        StWipe: begin
          mem[cnt] <= entropy_i;
          if (cnt == LastWord) begin
            state  <= StIdle;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(NumWords); g++) begin : g_key_map
    assign key_flat[g*WordWidth +: WordWidth] = mem[g];
  end

  assign wr_ready_o = (state == StLoad) && !clear_i;
  assign busy_o     = (state == StLoad) || (state == StWipe);
  assign done_o     = done_q;

  // Partial loads and wipe data stay hidden behind the valid bit.
  assign keymgr_key_o.valid = (state == StValid);
  assign keymgr_key_o.key   = (state == StValid) ? key_flat : '0;

endmodule

// File: tb/tb_keymgr_sideload_tx.sv
// Randomised bench for keymgr_sideload_tx checked every cycle against a behavioural key-slot model.
module tb_keymgr_sideload_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        load_start_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic [31:0] entropy_i = '0;
  logic        wr_ready_o;
  logic        busy_o;
  logic        done_o;
  logic [512:0] key_o;

  keymgr_sideload_tx dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_start_i (load_start_i),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_data_i    (wr_data_i),
    .clear_i      (clear_i),
    .entropy_i    (entropy_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keymgr_key_o (key_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;
  bit ent_fixed = 1'b0;
  logic [31:0] ent_val = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural key slot: a list of 16 words plus "loading", "holding" and "wipe cycles left".
  bit          m_loading = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_done = 1'b0;
  int          m_nloaded = 0;
  int          m_wipe_left = 0;
  logic [31:0] m_words [16];

  task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @%0t: timed out waiting for DUT", name, $time);
  endtask

  function automatic logic [512:0] exp_key();
    logic [511:0] k = '0;
    if (m_valid)
      for (int i = 0; i < 16; i++) k[i*32 +: 32] = m_words[i];
    return {m_valid, k};
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (rst_i) begin
      m_loading = 1'b0;
      m_valid = 1'b0;
      m_wipe_left = 0;
      m_nloaded = 0;
      for (int i = 0; i < 16; i++) m_words[i] = '0;
    end else if (m_wipe_left > 0) begin
      m_words[16 - m_wipe_left] = entropy_i;
      m_wipe_left--;
      if (m_wipe_left == 0) m_done = 1'b1;
    end else if (m_loading) begin
      if (clear_i) begin
        m_loading = 1'b0;
        m_wipe_left = 16;
      end else if (wr_valid_i) begin
        m_words[m_nloaded] = wr_data_i;
        m_nloaded++;
        if (m_nloaded == 16) begin
          m_loading = 1'b0;
          m_valid = 1'b1;
          m_done = 1'b1;
        end
      end
    end else if (m_valid) begin
      if (clear_i || load_start_i) begin
        m_valid = 1'b0;
        m_wipe_left = 16;
      end
    end else if (load_start_i && !clear_i) begin
      m_loading = 1'b1;
      m_nloaded = 0;
    end
  endtask

  initial begin : model_proc
    for (int i = 0; i < 16; i++) m_words[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin : cmp_proc
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("key", key_o, exp_key());
        check("busy", 513'(busy_o), 513'(m_loading || (m_wipe_left > 0)));
        check("ready", 513'(wr_ready_o), 513'(m_loading && !clear_i));
        check("done", 513'(done_o), 513'(m_done));
      end
    end
  end

  initial begin : entropy_proc
    forever begin
      @(posedge clk);
      #1;
      entropy_i = ent_fixed ? ent_val : $urandom;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog @%0t: simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, input string name, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done_o === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!seen) timeout_fail(name);
  endtask

  // Streams 16 words after a load_start pulse; optional clear on word clear_at or reset after rst_at words.
  task automatic load_key(input logic [31:0] w [16], input int stall_pct, input int clear_at,
                          input int rst_at, output int lat);
    int idx = 0;
    int guard = 0;
    int t0;
    bit hs;
    bit cleared;
    lat = -1;
    load_start_i = 1'b1;
    t0 = cyc_cnt;
    tick();
    load_start_i = 1'b0;
    while (idx < 16 && guard < 400) begin
      wr_valid_i = (int'($urandom_range(99)) >= stall_pct);
      wr_data_i = w[idx];
      clear_i = (idx == clear_at) && wr_valid_i;
      cleared = clear_i;
      @(negedge clk);
      hs = wr_valid_i && wr_ready_o;
      if (cleared) check("ready_low_on_clear", 513'(wr_ready_o), 513'(0));
      tick();
      clear_i = 1'b0;
      guard++;
      if (cleared) begin
        wr_valid_i = 1'b0;
        return;
      end
      if (hs) idx++;
      if (rst_at > 0 && idx == rst_at) begin
        wr_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_key_zero", key_o, 513'(0));
        check("rst_busy_zero", 513'(busy_o), 513'(0));
        check("rst_ready_zero", 513'(wr_ready_o), 513'(0));
        check("rst_mem9_zero", 513'(dut.mem[9]), 513'(0));
        tick();
        return;
      end
    end
    wr_valid_i = 1'b0;
    if (idx < 16) begin
      timeout_fail("load_words");
      return;
    end
    for (int c = 0; c < 50 && lat < 0; c++) begin
      @(negedge clk);
      if (key_o[512] === 1'b1) lat = cyc_cnt - t0;
      tick();
    end
    if (lat < 0) timeout_fail("load_valid");
  endtask

  logic [31:0] seq_words [16];
  logic [31:0] rnd_words [16];
  int lat;
  int cyc;
  int busy_cnt;

  initial begin : main
    for (int i = 0; i < 16; i++) seq_words[i] = 32'(i);

    repeat (3) tick();
    rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_key", key_o, 513'(0));
    check("reset_busy", 513'(busy_o), 513'(0));
    check("reset_ready", 513'(wr_ready_o), 513'(0));
    check("reset_done", 513'(done_o), 513'(0));
    tick();

    // Back-to-back load of 0..15
    load_key(seq_words, 0, -1, -1, lat);
    check("load_latency", 513'(lat), 513'(17));
    check("key_w0", 513'(key_o[31:0]), 513'(32'h0));
    check("key_w8", 513'(key_o[287:256]), 513'(32'h8));
    check("key_w15", 513'(key_o[511:480]), 513'(32'hF));
    check("key_valid", 513'(key_o[512]), 513'(1));
    check("done_single_pulse", 513'(done_o), 513'(0));

    // Clear in VALID with constant entropy
    ent_val = 32'hA5A5A5A5;
    ent_fixed = 1'b1;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) check("valid_drop", 513'(key_o[512]), 513'(0));
      if (done_o === 1'b1) break;
      if (busy_o === 1'b1) busy_cnt++;
      cyc++;
      tick();
    end
    if (cyc >= 40) timeout_fail("wipe_done");
    else tick();
    check("wipe_busy_cycles", 513'(busy_cnt), 513'(16));
    for (int i = 0; i < 16; i++) check("wipe_mem", 513'(dut.mem[i]), 513'(32'hA5A5A5A5));
    check("wipe_key_hidden", key_o, 513'(0));
    ent_fixed = 1'b0;

    // Stalled load of the same words gives the same key
    load_key(seq_words, 40, -1, -1, lat);
    check("stall_key_w0", 513'(key_o[31:0]), 513'(32'h0));
    check("stall_key_w8", 513'(key_o[287:256]), 513'(32'h8));
    check("stall_key_w15", 513'(key_o[511:480]), 513'(32'hF));

    // load_start in VALID wipes, then loading needs a fresh request
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    wait_done(40, "reload_wipe", cyc);
    wr_valid_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("no_ready_without_start", 513'(wr_ready_o), 513'(0));
      tick();
    end
    wr_valid_i = 1'b0;

    // Clear coincident with the 5th handshake
    for (int i = 0; i < 16; i++) rnd_words[i] = $urandom;
    load_key(rnd_words, 0, 4, -1, lat);
    wait_done(40, "clear_in_load", cyc);

    // Reset after the 10th word, then a full random load
    load_key(rnd_words, 20, -1, 10, lat);
    load_key(rnd_words, 30, -1, -1, lat);
    check("post_rst_w3", 513'(key_o[127:96]), 513'(rnd_words[3]));
    check("post_rst_w12", 513'(key_o[415:384]), 513'(rnd_words[12]));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    wait_done(40, "post_rst_wipe", cyc);

    // Start and clear together in IDLE stay idle
    load_start_i = 1'b1;
    clear_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    clear_i = 1'b0;
    @(negedge clk);
    check("idle_clear_wins", 513'(busy_o), 513'(0));
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(999) < 3);
      load_start_i = ($urandom_range(99) < 6);
      clear_i = ($urandom_range(99) < 3);
      wr_valid_i = ($urandom_range(99) < 70);
      wr_data_i = $urandom;
      tick();
    end
    rst_i = 1'b0;
    load_start_i = 1'b0;
    clear_i = 1'b0;
    wr_valid_i = 1'b0;
    repeat (2) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
